// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolator sample sequencer.
package interp_pkg;

    localparam int DATA_W        = 8;
    localparam int DEFAULT_RATIO = 25;
    localparam int MIN_RATIO     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/interp_phase_cnt.sv
// Modulo-R phase counter: sync clear, free-running increment, terminal-count flag at R-1.
module interp_phase_cnt #(
    parameter int RATIO_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [RATIO_W-1:0] ratio,
    output logic [RATIO_W-1:0] phase,
    output logic               tc
);

    assign tc = (phase == ratio - RATIO_W'(1));

    // Phase register: wraps to 0 after the terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            phase <= '0;
        else if (clr)
            phase <= '0;
        else if (en)
            phase <= tc ? '0 : phase + RATIO_W'(1);
    end

endmodule

// File: rtl/interp_ctrl.sv
// Sample sequencer for the linear interpolator: fetches one sample per frame of
// R fast cycles, strobes the load, and repeats the held sample on underrun.
// Optional build macro: INTERP_CTRL_UNDERRUN_CNT_EN adds a saturating underrun counter.
module interp_ctrl #(
    parameter int DATA_W        = interp_pkg::DATA_W,
    parameter int RATIO_W       = 6,
    parameter int DEFAULT_RATIO = interp_pkg::DEFAULT_RATIO,
    parameter int CNT_W         = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable_i,
    input  logic [RATIO_W-1:0] ratio_i,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    output logic               load_o,
    output logic [DATA_W-1:0]  sample_o,
    output logic [RATIO_W-1:0] phase_o,
    output logic               running_o,
    output logic               underrun_o,
    output logic [CNT_W-1:0]   underrun_cnt_o
);

    import interp_pkg::*;

    state_t             state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_sel;
    logic [DATA_W-1:0]  sample_q;
    logic               load_q, load_d;
    logic               under_q, under_d;
    logic               running_q;
    logic               latch_ratio;
    logic               accept;
    logic               tc;

    assign accept = s_ready & s_valid;

    // Ratio sanitising: 0 selects the default, 1 is raised to the minimum usable ratio.
    always_comb begin
        ratio_sel = ratio_i;
        if (ratio_i == '0)
            ratio_sel = RATIO_W'(DEFAULT_RATIO);
        else if (ratio_i == RATIO_W'(1))
            ratio_sel = RATIO_W'(MIN_RATIO);
    end

    interp_phase_cnt #(.RATIO_W(RATIO_W)) u_phase (
        .clock (clock),
        .reset (reset),
        .clr   (state_q != RUN),
        .en    (1'b1),
        .ratio (ratio_q),
        .phase (phase_o),
        .tc    (tc)
    );

    // Next-state, handshake and strobe decode.
    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        load_d      = 1'b0;
        under_d     = 1'b0;
        latch_ratio = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d     = PRIME;
                    latch_ratio = 1'b1;
                end
            end
            PRIME: begin
                // Ready is withdrawn together with enable so a stop never completes a handshake.
                s_ready = enable_i;
                if (!enable_i)
                    state_d = IDLE;
                else if (s_valid) begin
                    load_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tc) begin
                    if (enable_i) begin
                        s_ready = 1'b1;
                        // Load every frame; without a new sample the held one is re-loaded.
                        load_d  = 1'b1;
                        under_d = ~s_valid;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched ratio, held sample and registered strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ratio_q   <= RATIO_W'(DEFAULT_RATIO);
            sample_q  <= '0;
            load_q    <= 1'b0;
            under_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (latch_ratio)
                ratio_q <= ratio_sel;
            if (accept)
                sample_q <= s_data;
            load_q    <= load_d;
            under_q   <= under_d;
            running_q <= (state_d == RUN);
        end
    end

    assign load_o     = load_q;
    assign sample_o   = sample_q;
    assign underrun_o = under_q;
    assign running_o  = running_q;

`ifdef INTERP_CTRL_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] ucnt_q;

    // Saturating underrun count, updated in step with the underrun pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ucnt_q <= '0;
        else if (latch_ratio)
            ucnt_q <= '0;
        else if (under_d && (ucnt_q != '1))
            ucnt_q <= ucnt_q + CNT_W'(1);
    end

    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_cnt_o = '0;
`endif

endmodule

// File: doc/interp_ctrl.md
Name: interp_ctrl

Overview:
Sample sequencer for the 50x/25x linear interpolator datapath. It pulls 8-bit samples from an upstream source over a valid/ready handshake, one per interpolation frame of RATIO fast-clock cycles. It drives the interpolator's load strobe, sample value and phase index. On underrun it repeats the last sample, so the datapath produces a flat segment instead of garbage.

Parameters:
DATA_W, 8, sample width (matches interpolator v_in)
RATIO_W, 6, width of ratio and phase fields
DEFAULT_RATIO, 25, ratio used when ratio_i is 0
CNT_W, 16, underrun counter width (optional feature only)

Ports:
clock  in  1  fast clock (same domain as interpolator)
reset  in  1  asynchronous, active-high reset
enable_i  in  1  run request; level-sensitive
ratio_i  in  RATIO_W  fast cycles per sample; latched on IDLE->PRIME
s_valid  in  1  upstream sample valid
s_data  in  DATA_W  upstream sample
s_ready  out  1  controller accepts s_data this cycle
load_o  out  1  one-cycle pulse: interpolator loads sample_o as new endpoint
sample_o  out  DATA_W  current endpoint sample to interpolator
phase_o  out  RATIO_W  position within frame, 0..R-1
running_o  out  1  high in RUN
underrun_o  out  1  one-cycle pulse: frame boundary with no sample available
underrun_cnt_o  out  CNT_W  saturating underrun count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: s_ready, load_o, sample_o, phase_o, running_o, underrun_o, underrun_cnt_o. Latched ratio R=DEFAULT_RATIO.
- Ratio latch: R = ratio_i; ratio_i==0 -> DEFAULT_RATIO; ratio_i==1 -> 2 (MIN_RATIO). R is frozen until the next IDLE->PRIME transition. ratio_i changes during PRIME/RUN are ignored.
- IDLE: s_ready=0, phase_o=0, sample_o holds its last value. enable_i=1 -> latch R, go to PRIME.
- PRIME: s_ready=1 combinationally. Accept (s_valid & s_ready) -> next cycle: sample_o=s_data, load_o=1, phase_o=0, state RUN. enable_i=0 while in PRIME -> IDLE with no accept.
- RUN: phase_o increments each cycle and wraps R-1 -> 0. s_ready=1 only when phase_o==R-1 and enable_i=1.
  - At phase R-1 with accept: next cycle sample_o=s_data, load_o=1, phase_o=0.
  - At phase R-1 with no valid: next cycle sample_o unchanged, load_o=1 (re-load of the held value gives a flat segment), underrun_o=1, phase_o=0.
  - At phase R-1 with enable_i=0: no accept, no load, state IDLE, phase_o=0. The frame always completes, so no partial frame on stop.
- Latency: accept at cycle t -> load_o and sample_o at t+1. Exactly one load_o per frame in RUN; loads are spaced exactly R cycles apart.
- s_valid when s_ready=0 is ignored; upstream must hold the data. s_ready never depends on s_valid.
- Reset mid-frame: immediate return to IDLE, outputs cleared; no pending load is issued.
- running_o = (state==RUN), registered.

Optional Feature:
- Macro: INTERP_CTRL_UNDERRUN_CNT_EN.
- Defined: underrun_cnt_o increments on each underrun_o pulse and saturates at all ones. It is cleared by reset and on IDLE->PRIME.
- Undefined: the counter is not built and underrun_cnt_o is tied to 0. underrun_o pulse behaviour is unchanged.

Decomposition:
- Package interp_pkg:
  - state typedef {IDLE, PRIME, RUN}
  - constants DEFAULT_RATIO=25, MIN_RATIO=2, DATA_W=8
- Sub-module interp_phase_cnt: modulo-R counter with sync clear and terminal-count flag (phase==R-1). It is instantiated once for phase_o.

Test Plan:
1. Reset, enable_i=1, ratio_i=25, s_valid always 1 with data 0x10, 0x20, 0x30 -> loads 25 cycles apart; sample_o sequence 0x10, 0x20, 0x30; underrun_o never asserts.
2. ratio_i=0 -> R=25; ratio_i=1 -> R=2; ratio_i=4 -> load_o period 4 cycles and phase_o sequence 0,1,2,3,0.
3. RUN with R=25, s_valid=0 over one frame boundary -> load_o=1, sample_o holds previous value, underrun_o=1 one cycle; with the macro defined, underrun_cnt_o goes 0->1.
4. Drop enable_i at phase 10 of a frame -> phase continues to 24, no accept, IDLE next cycle, s_ready stays 0.
5. Assert reset at phase 12 -> same cycle all outputs 0, state IDLE; after release and enable_i=1, PRIME accepts the first sample normally.
6. Change ratio_i 25->10 mid-RUN -> period stays 25 until disable/re-enable, then becomes 10.
